// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//
// General-purpose register file for the single-cycle CPU. It holds 2**ADDR_W
// registers of DATA_W bits. Register 0 always reads as zero. There are two
// combinational read ports for the rs/rt operands and one clocked write port.
// An optional same-cycle write-to-read bypass is provided. A debug read port
// always shows stored state. A committed-write counter supports bench and
// board observation.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  register address width (depth = 2**ADDR_W)
//   BYPASS  1: a read of the register being written returns WriteData
//           0: a read of the register being written returns the stored value
//   CNT_W   width of the committed-write counter (wraps, no saturation)
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst_n      in   async active-low reset; clears registers and counter
//   RegWrite   in   write enable from the control unit
//   WriteReg   in   destination register (from the RegDst mux)
//   WriteData  in   write-back value
//   ReadReg1   in   rs address
//   ReadReg2   in   rt address
//   ReadData1  out  rs value, combinational
//   ReadData2  out  rt value, combinational
//   dbg_addr   in   debug read address
//   dbg_data   out  debug read value, combinational, never bypassed
//   wr_count   out  number of committed writes, modulo 2**CNT_W
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [CNT_W-1:0]  r_wr_count;

    // A write commits only when it targets a real register. Writes to r0 are
    // dropped and are not counted.
    logic w_commit;
    assign w_commit = RegWrite && (WriteReg != '0);

    // -------------------------------------------------------------------------
    // Storage
    // Each register has its own decoded enable. An unknown address with
    // RegWrite low therefore cannot disturb any entry. Entry 0 is never
    // written and stays at its reset value.
    // -------------------------------------------------------------------------
    // NOTE: the whole array is cleared by the async reset because the CPU
    // relies on every register reading 0 right after reset. This makes the
    // array flops rather than RAM, which suits a 32-entry file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                // NOTE: non-blocking assignments keep every flop updating
                // from pre-edge values, independent of statement order.
                if (w_commit && (WriteReg == ADDR_W'(i))) begin
                    r_regs[i] <= WriteData;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Committed-write counter, updated on the same edge as the write
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_wr_count <= r_wr_count + CNT_W'(1);
        end
    end

    assign wr_count = r_wr_count;

    // -------------------------------------------------------------------------
    // Read ports
    // Priority: r0 -> 0, then the bypass hit -> WriteData, then stored value.
    // The bypass deliberately ignores rst_n. During reset the stored value is
    // already 0, and a bypassed read still shows WriteData.
    // -------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] sel_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] value;
        if (addr == '0) begin
            value = '0;
        end else if ((BYPASS != 0) && RegWrite && (addr == WriteReg)) begin
            value = WriteData;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_dbg;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        w_rd1 = '0;
        w_rd2 = '0;
        w_dbg = '0;

        w_rd1 = sel_read(ReadReg1, r_regs[ReadReg1]);
        w_rd2 = sel_read(ReadReg2, r_regs[ReadReg2]);

        // The debug port shows committed state only and never takes the bypass.
        if (dbg_addr != '0) begin
            w_dbg = r_regs[dbg_addr];
        end
    end

    assign ReadData1 = w_rd1;
    assign ReadData2 = w_rd2;
    assign dbg_data  = w_dbg;

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
//
// Directed bench for reg_file. Two instances share all inputs:
//   u_dut_byp : BYPASS=1, CNT_W=4  (bypass behaviour and counter wrap)
//   u_dut_nob : BYPASS=0, CNT_W=16 (non-bypassed reads, wide counter)
// Expected values are hand-computed constants. The expected commit count is
// kept in `exp_cnt` and masked to each instance's counter width.
// -----------------------------------------------------------------------------
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  dbg_addr;

    logic [31:0] rd1_b, rd2_b, dbg_b;
    logic [3:0]  wc_b;
    logic [31:0] rd1_n, rd2_n, dbg_n;
    logic [15:0] wc_n;

    int n_total = 0;
    int n_bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(4)) u_dut_byp (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (rd1_b),
        .ReadData2 (rd2_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_b),
        .wr_count  (wc_b)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(16)) u_dut_nob (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (rd1_n),
        .ReadData2 (rd2_n),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_n),
        .wr_count  (wc_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Both counters are compared against the expected commit count, wrapped
    // to each instance's width.
    task automatic check_counts(input string tag);
        check({tag, "_cnt_byp"}, 32'(wc_b), exp_cnt & 32'h0000_000F);
        check({tag, "_cnt_nob"}, 32'(wc_n), exp_cnt & 32'h0000_FFFF);
    endtask

    // Called at a falling edge. It presents a write for the next rising edge
    // and returns at the following falling edge. Back-to-back calls therefore
    // write on consecutive edges.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        RegWrite  = 1'b1;
        WriteReg  = a;
        WriteData = d;
        @(negedge clk);
        RegWrite  = 1'b0;
        if (a != 5'd0) exp_cnt++;
    endtask

    task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        ReadReg1 = a1;
        ReadReg2 = a2;
        dbg_addr = ad;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        ReadReg1  = 5'd1;
        ReadReg2  = 5'd31;
        dbg_addr  = 5'd1;

        // ---- reset state ----
        #12;
        check("rst_rd1_byp", rd1_b, 32'h0);
        check("rst_rd2_nob", rd2_n, 32'h0);
        check("rst_dbg_nob", dbg_n, 32'h0);
        check_counts("rst");

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- reset mid-program loses state immediately ----
        write_reg(5'd5, 32'h0000_1234);
        set_reads(5'd5, 5'd5, 5'd5);
        check("pre_rst_dbg_r5", dbg_b, 32'h0000_1234);
        check("pre_rst_rd1_r5", rd1_n, 32'h0000_1234);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("mid_rst_rd1_byp", rd1_b, 32'h0);
        check("mid_rst_rd1_nob", rd1_n, 32'h0);
        check("mid_rst_dbg_byp", dbg_b, 32'h0);
        check_counts("mid_rst");

        // A write held across an edge during reset must not commit. The
        // bypassed read still shows WriteData.
        RegWrite  = 1'b1;
        WriteReg  = 5'd6;
        WriteData = 32'h0000_0ABC;
        set_reads(5'd6, 5'd6, 5'd6);
        check("rst_bypass_rd1", rd1_b, 32'h0000_0ABC);
        check("rst_nobyp_rd1", rd1_n, 32'h0);
        @(negedge clk);
        check("rst_nocommit_dbg", dbg_b, 32'h0);
        RegWrite = 1'b0;
        #1;
        rst_n = 1'b1;
        check_counts("rst_nocommit");
        @(negedge clk);

        // ---- basic write / read, consecutive edges ----
        write_reg(5'd1, 32'hDEAD_BEEF);
        write_reg(5'd31, 32'h0000_0001);
        set_reads(5'd1, 5'd31, 5'd31);
        check("basic_rd1_byp", rd1_b, 32'hDEAD_BEEF);
        check("basic_rd2_byp", rd2_b, 32'h0000_0001);
        check("basic_rd1_nob", rd1_n, 32'hDEAD_BEEF);
        check("basic_rd2_nob", rd2_n, 32'h0000_0001);
        check("basic_dbg_r31", dbg_n, 32'h0000_0001);
        check_counts("basic");

        // ---- zero register: write dropped, r0 never bypassed ----
        RegWrite  = 1'b1;
        WriteReg  = 5'd0;
        WriteData = 32'hFFFF_FFFF;
        set_reads(5'd0, 5'd0, 5'd0);
        check("zero_bypass_rd1", rd1_b, 32'h0);
        @(negedge clk);
        RegWrite = 1'b0;
        #1;
        check("zero_rd1_byp", rd1_b, 32'h0);
        check("zero_rd2_nob", rd2_n, 32'h0);
        check("zero_dbg", dbg_b, 32'h0);
        check_counts("zero");

        // ---- bypass vs no bypass ----
        write_reg(5'd7, 32'h0000_0011);
        RegWrite  = 1'b1;
        WriteReg  = 5'd7;
        WriteData = 32'h0000_0022;
        set_reads(5'd7, 5'd7, 5'd7);
        check("byp_rd1", rd1_b, 32'h0000_0022);
        check("byp_rd2", rd2_b, 32'h0000_0022);
        check("byp_dbg", dbg_b, 32'h0000_0011);
        check("nob_rd1", rd1_n, 32'h0000_0011);
        check("nob_rd2", rd2_n, 32'h0000_0011);
        @(negedge clk);
        RegWrite = 1'b0;
        exp_cnt++;
        #1;
        check("post_byp_rd1", rd1_b, 32'h0000_0022);
        check("post_byp_dbg", dbg_b, 32'h0000_0022);
        check("post_nob_rd1", rd1_n, 32'h0000_0022);
        check("post_nob_rd2", rd2_n, 32'h0000_0022);
        check("post_nob_dbg", dbg_n, 32'h0000_0022);
        check_counts("bypass");

        // ---- RegWrite gating, then an unknown address with RegWrite low ----
        RegWrite  = 1'b0;
        WriteReg  = 5'd9;
        WriteData = 32'h0000_0055;
        set_reads(5'd9, 5'd9, 5'd9);
        check("gate_bypass_off", rd1_b, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check("gate_r9_byp", dbg_b, 32'h0);
        check("gate_r9_nob", rd1_n, 32'h0);
        check_counts("gate");
        WriteReg = 'x;
        @(negedge clk);
        WriteReg = 5'd0;
        set_reads(5'd1, 5'd31, 5'd7);
        check("xaddr_r1", rd1_b, 32'hDEAD_BEEF);
        check("xaddr_r31", rd2_n, 32'h0000_0001);
        check("xaddr_r7", dbg_b, 32'h0000_0022);
        check_counts("xaddr");

        // ---- counter wrap: 17 back-to-back writes to r3 from a fresh reset ----
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 17; i++) begin
            write_reg(5'd3, 32'h0000_0100 + 32'(i));
        end
        set_reads(5'd3, 5'd1, 5'd3);
        check("wrap_cnt_byp_lit", 32'(wc_b), 32'd1);
        check("wrap_cnt_nob_lit", 32'(wc_n), 32'd17);
        check("wrap_r3_byp", dbg_b, 32'h0000_0111);
        check("wrap_r3_nob", rd1_n, 32'h0000_0111);
        check("wrap_r1_cleared", rd2_b, 32'h0);
        check_counts("wrap");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
